// File: rtl/puf_challenge_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : puf_challenge_sequencer
// Description : Challenge-side sequencer for the PDL PUF. Applies a 64-bit
//               LFSR challenge, fires a one-cycle launch pulse, waits for the
//               delay lines to settle and samples the XORed response. Bits are
//               packed into a RESP_BITS word and handed off over valid/ready.
//               Optional majority voting over EVALS evaluations per bit is
//               compiled in with macro PUF_MAJORITY_VOTE_EN.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start, challenge_seed - run request and initial challenge
//               xor_response       - XORed PUF output bit
//               challenge          - challenge vector to the PDL rows
//               puf_trigger        - one-cycle launch pulse
//               busy               - high whenever not IDLE
//               response_word      - collected bits (bit k = k-th bit)
//               resp_valid, resp_ready - output handshake
//               unstable_cnt       - bits whose evaluations disagreed
// Revision    : 1.0 - initial release
// ============================================================================
module puf_challenge_sequencer #(
  parameter int RESP_BITS     = 32,
  parameter int SETTLE_CYCLES = 8,
  parameter int EVALS         = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [63:0]          challenge_seed,
  input  logic                 xor_response,
  output logic [63:0]          challenge,
  output logic                 puf_trigger,
  output logic                 busy,
  output logic [RESP_BITS-1:0] response_word,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [7:0]           unstable_cnt
);

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int EFF_EVALS = EVALS;
`else
  // Single evaluation per bit; EVALS only matters when voting is built in.
  localparam int EFF_EVALS = (EVALS > 0) ? 1 : 1;
`endif
  localparam int BIT_W = $clog2(RESP_BITS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [7:0]           r_settle;
  logic [3:0]           r_eval;
  logic [3:0]           r_ones;
  logic [BIT_W-1:0]     r_bit;
  logic [63:0]          r_challenge;
  logic [RESP_BITS-1:0] r_word;

  logic [3:0]           w_eval_next;
  logic [3:0]           w_ones_next;
  logic                 w_eval_done;
  logic                 w_bit_value;
  logic                 w_last_bit;
  logic                 w_settle_done;
  logic [63:0]          w_lfsr_next;
  logic [RESP_BITS-1:0] w_bit_mask;

  assign w_eval_next   = r_eval + 4'd1;
  assign w_ones_next   = r_ones + {3'd0, xor_response};
  assign w_eval_done   = (w_eval_next == 4'(EFF_EVALS));
  assign w_bit_value   = (w_ones_next > 4'(EFF_EVALS / 2));
  assign w_last_bit    = (r_bit == BIT_W'(RESP_BITS - 1));
  assign w_settle_done = (r_settle == 8'(SETTLE_CYCLES - 1));
  // x^64+x^63+x^61+x^60+1 Fibonacci step, shifting toward the MSB.
  assign w_lfsr_next   = {r_challenge[62:0],
                          r_challenge[63] ^ r_challenge[62] ^
                          r_challenge[60] ^ r_challenge[59]};
  assign w_bit_mask    = RESP_BITS'(1) << r_bit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_LAUNCH;
      S_LAUNCH: w_state_next = S_SETTLE;
      S_SETTLE: if (w_settle_done) w_state_next = S_SAMPLE;
      S_SAMPLE: begin
        if (w_eval_done && w_last_bit) w_state_next = S_DONE;
        else                           w_state_next = S_LAUNCH;
      end
      S_DONE:   if (resp_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    puf_trigger = (r_state == S_LAUNCH);
    busy        = (r_state != S_IDLE);
    resp_valid  = (r_state == S_DONE);
  end

`ifdef PUF_MAJORITY_VOTE_EN
  logic [7:0] r_unstable;
  logic       w_disagree;
  assign w_disagree   = (w_ones_next != 4'd0) && (w_ones_next != 4'(EFF_EVALS));
  assign unstable_cnt = r_unstable;
`else
  assign unstable_cnt = 8'd0;
`endif

  // Datapath: challenge, counters and response accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle    <= 8'd0;
      r_eval      <= 4'd0;
      r_ones      <= 4'd0;
      r_bit       <= '0;
      r_challenge <= 64'd0;
      r_word      <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
      r_unstable  <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // An all-zero state would lock the LFSR, so substitute 1.
            r_challenge <= (challenge_seed == 64'd0) ? 64'd1 : challenge_seed;
            r_word      <= '0;
            r_bit       <= '0;
            r_eval      <= 4'd0;
            r_ones      <= 4'd0;
`ifdef PUF_MAJORITY_VOTE_EN
            r_unstable  <= 8'd0;
`endif
          end
        end
        S_LAUNCH: r_settle <= 8'd0;
        S_SETTLE: r_settle <= r_settle + 8'd1;
        S_SAMPLE: begin
          if (!w_eval_done) begin
            r_eval <= w_eval_next;
            r_ones <= w_ones_next;
          end else begin
            r_eval      <= 4'd0;
            r_ones      <= 4'd0;
            // Word was cleared at start, so OR-ing in set bits is enough.
            if (w_bit_value) r_word <= r_word | w_bit_mask;
`ifdef PUF_MAJORITY_VOTE_EN
            if (w_disagree && (r_unstable != 8'hFF)) r_unstable <= r_unstable + 8'd1;
`endif
            r_challenge <= w_lfsr_next;
            r_bit       <= r_bit + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign challenge     = r_challenge;
  assign response_word = r_word;

endmodule
`default_nettype wire

// File: tb/tb_puf_challenge_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_puf_challenge_sequencer
// Description : Self-checking bench for puf_challenge_sequencer with
//               RESP_BITS=4, SETTLE_CYCLES=2, EVALS=3. Expectations follow
//               whether PUF_MAJORITY_VOTE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_challenge_sequencer;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int EFF = 3;
`else
  localparam int EFF = 1;
`endif
  localparam int LAT = 1 + 4 * EFF * 4;

  logic        clk = 1'b0;
  logic        reset, start, xor_response, resp_ready;
  logic [63:0] challenge_seed, challenge;
  logic        puf_trigger, busy, resp_valid;
  logic [3:0]  response_word;
  logic [7:0]  unstable_cnt;

  int checks = 0;
  int errors = 0;

  puf_challenge_sequencer #(
    .RESP_BITS(4), .SETTLE_CYCLES(2), .EVALS(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge_seed(challenge_seed),
    .xor_response(xor_response), .challenge(challenge), .puf_trigger(puf_trigger),
    .busy(busy), .response_word(response_word), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .unstable_cnt(unstable_cnt)
  );

  always #5 clk = ~clk;

  // samples[b*3+e] = response for bit b, evaluation e
  typedef struct {
    logic [63:0] seed;
    logic [11:0] samples;
    logic [3:0]  exp_word;
    logic [7:0]  exp_unstable;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [63:0] lfsr_step(input logic [63:0] c);
    return {c[62:0], c[63] ^ c[62] ^ c[60] ^ c[59]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts a run and follows it until resp_valid, checking every launch.
  task automatic run_vec(input vec_t v);
    int n, trig, b, e, cur_b;
    logic [63:0] exp_chal;
    logic done;
    @(negedge clk);
    challenge_seed = v.seed;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; trig = 0; cur_b = 0; done = 1'b0;
    exp_chal = (v.seed == 64'd0) ? 64'd1 : v.seed;
    while (n <= 500 && !done) begin
      if (resp_valid) begin
        done = 1'b1;
      end else begin
        if (puf_trigger) begin
          b = trig / EFF;
          e = trig % EFF;
          if (b != cur_b) begin
            exp_chal = lfsr_step(exp_chal);
            cur_b = b;
          end
          chk("challenge_at_launch", challenge, exp_chal);
          if (b < 4) xor_response = v.samples[b*3+e];
          trig++;
        end
        @(negedge clk);
        n++;
      end
    end
    chk("resp_valid_seen", {63'd0, done}, 64'd1);
    chk("latency", 64'(n), 64'(LAT));
    chk("trigger_count", 64'(trig), 64'(4 * EFF));
    chk("response_word", {60'd0, response_word}, {60'd0, v.exp_word});
    chk("unstable_cnt", {56'd0, unstable_cnt}, {56'd0, v.exp_unstable});
    chk("challenge_in_done", challenge, lfsr_step(exp_chal));
    chk("busy_in_done", {63'd0, busy}, 64'd1);
    xor_response = 1'b0;
  endtask

  task automatic handshake(input logic [3:0] exp_word);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("valid_after_ready", {63'd0, resp_valid}, 64'd0);
    chk("busy_after_ready", {63'd0, busy}, 64'd0);
    chk("word_held_in_idle", {60'd0, response_word}, {60'd0, exp_word});
  endtask

  initial begin
    int trig;
    vecs[0] = '{64'hA5, 12'hFFF, 4'hF, 8'd0};
`ifdef PUF_MAJORITY_VOTE_EN
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 12'h015, 4'b0001, 8'd2};
    vecs[2] = '{64'hDEAD_BEEF_0000_0001, 12'h07E, 4'b0011, 8'd2};
`else
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 12'h015, 4'b0001, 8'd0};
    vecs[2] = '{64'hDEAD_BEEF_0000_0001, 12'h07E, 4'b0110, 8'd0};
`endif
    vecs[3] = '{64'h0, 12'h000, 4'h0, 8'd0};

    reset = 1'b1; start = 1'b0; xor_response = 1'b0; resp_ready = 1'b0;
    challenge_seed = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_challenge", challenge, 64'd0);
    chk("rst_trigger", {63'd0, puf_trigger}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_word", {60'd0, response_word}, 64'd0);
    chk("rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_unstable", {56'd0, unstable_cnt}, 64'd0);
    reset = 1'b0;

    // Table-driven runs: constant one, majority patterns, zero seed
    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i]);
      handshake(vecs[i].exp_word);
    end

    // Backpressure with start pulsed during DONE
    run_vec(vecs[0]);
    for (int c = 0; c < 10; c++) begin
      start = (c == 3);
      @(negedge clk);
      chk("bp_valid_hold", {63'd0, resp_valid}, 64'd1);
      chk("bp_word_hold", {60'd0, response_word}, 64'hF);
    end
    start = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    resp_ready = 1'b0;
    chk("bp_release_valid", {63'd0, resp_valid}, 64'd0);
    chk("bp_release_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("bp_no_restart", {63'd0, busy}, 64'd0);

    // Reset during SETTLE of bit 2
    challenge_seed = vecs[2].seed;
    start = 1'b1;
    trig = 0;
    for (int n = 0; n < 300 && trig < 2 * EFF + 1; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (puf_trigger) trig++;
    end
    chk("midrun_reached_bit2", 64'(trig), 64'(2 * EFF + 1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_rst_challenge", challenge, 64'd0);
    chk("midrun_rst_busy", {63'd0, busy}, 64'd0);
    chk("midrun_rst_word", {60'd0, response_word}, 64'd0);
    chk("midrun_rst_trigger", {63'd0, puf_trigger}, 64'd0);
    chk("midrun_rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("midrun_rst_unstable", {56'd0, unstable_cnt}, 64'd0);
    run_vec(vecs[2]);
    handshake(vecs[2].exp_word);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
